// File: rtl/wb_retire_queue.sv
// Multi-lane writeback retire queue: buffers io groups in order, drains up to
// WRITE_PORTS entries per cycle to the register file and answers ID forwarding lookups.
module wb_retire_queue #(
  parameter int LANES        = 2,
  parameter int WRITE_PORTS  = 1,
  parameter int DEPTH        = 4,
  parameter int LOOKUP_PORTS = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_allow_in,
  input  logic [LANES-1:0]                   in_lane_valid,
  input  logic [LANES-1:0]                   in_write_enabled,
  input  logic [4*LANES-1:0]                 in_write_strobe,
  input  logic [5*LANES-1:0]                 in_write_address,
  input  logic [DATA_WIDTH*LANES-1:0]        in_write_data,
  input  logic [DATA_WIDTH*LANES-1:0]        in_program_count,
  input  logic                               flush,
  output logic [WRITE_PORTS-1:0]             rf_write_enabled,
  output logic [4*WRITE_PORTS-1:0]           rf_write_strobe,
  output logic [5*WRITE_PORTS-1:0]           rf_write_address,
  output logic [DATA_WIDTH*WRITE_PORTS-1:0]  rf_write_data,
  input  logic [5*LOOKUP_PORTS-1:0]          lookup_address,
  output logic [LOOKUP_PORTS-1:0]            lookup_hit,
  output logic [LOOKUP_PORTS-1:0]            lookup_partial,
  output logic [DATA_WIDTH*LOOKUP_PORTS-1:0] lookup_data,
  output logic [DATA_WIDTH*WRITE_PORTS-1:0]  debug_program_count,
  output logic [4*WRITE_PORTS-1:0]           debug_write_enabled,
  output logic [5*WRITE_PORTS-1:0]           debug_write_address,
  output logic [DATA_WIDTH*WRITE_PORTS-1:0]  debug_write_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(LANES + 1);

  logic                  ent_we_reg   [DEPTH];
  logic [3:0]            ent_strb_reg [DEPTH];
  logic [4:0]            ent_addr_reg [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_reg [DEPTH];
  logic [DATA_WIDTH-1:0] ent_pc_reg   [DEPTH];

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] drain_num;
  logic [LW-1:0] enq_num;
  logic [LW-1:0] lane_off [LANES];
  logic [AW-1:0] wr_idx   [LANES];
  logic          enq_fire;

  assign in_allow_in = (32'(count_reg) + 32'(LANES)) <= 32'(DEPTH);
  assign enq_fire    = in_valid && in_allow_in && !flush;
  assign drain_num   = (32'(count_reg) < 32'(WRITE_PORTS)) ? count_reg : CW'(WRITE_PORTS);

  // Valid lanes are packed together: each lane's slot offset is the number of valid lanes before it.
  always_comb begin
    enq_num = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = enq_num;
      enq_num     = enq_num + LW'(in_lane_valid[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_wr_idx
      assign wr_idx[gi] = tail_reg + AW'(lane_off[gi]);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_lane_valid[i]) begin
          ent_we_reg[wr_idx[i]]   <= in_write_enabled[i];
          ent_strb_reg[wr_idx[i]] <= in_write_strobe[i*4 +: 4];
          ent_addr_reg[wr_idx[i]] <= in_write_address[i*5 +: 5];
          ent_data_reg[wr_idx[i]] <= in_write_data[i*DATA_WIDTH +: DATA_WIDTH];
          ent_pc_reg[wr_idx[i]]   <= in_program_count[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    head_next  = head_reg + AW'(drain_num);
    tail_next  = tail_reg + (enq_fire ? AW'(enq_num) : AW'(0));
    count_next = count_reg + (enq_fire ? CW'(enq_num) : CW'(0)) - drain_num;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  generate
    for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_port
      logic [AW-1:0] idx;
      logic          active;
      assign idx    = head_reg + AW'(gi);
      assign active = 32'(count_reg) > 32'(gi);
      assign rf_write_enabled[gi]                          = active && ent_we_reg[idx] && !flush;
      assign rf_write_strobe[gi*4 +: 4]                    = ent_strb_reg[idx];
      assign rf_write_address[gi*5 +: 5]                   = ent_addr_reg[idx];
      assign rf_write_data[gi*DATA_WIDTH +: DATA_WIDTH]    = ent_data_reg[idx];
      assign debug_write_enabled[gi*4 +: 4]                = {4{rf_write_enabled[gi]}} & ent_strb_reg[idx];
      assign debug_write_address[gi*5 +: 5]                = ent_addr_reg[idx];
      assign debug_write_data[gi*DATA_WIDTH +: DATA_WIDTH] = ent_data_reg[idx];
      assign debug_program_count[gi*DATA_WIDTH +: DATA_WIDTH] = ent_pc_reg[idx];
    end
  endgenerate

  // Entries listed oldest-first so the youngest match overrides during the scan.
  logic [AW-1:0]    scan_idx [DEPTH];
  logic [DEPTH-1:0] scan_valid;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_scan
      assign scan_idx[gi]   = head_reg + AW'(gi);
      assign scan_valid[gi] = 32'(count_reg) > 32'(gi);
    end
  endgenerate

  generate
    for (gi = 0; gi < LOOKUP_PORTS; gi++) begin : g_lookup
      logic [4:0]            addr;
      logic                  hit;
      logic                  part;
      logic [DATA_WIDTH-1:0] data;
      assign addr = lookup_address[gi*5 +: 5];
      always_comb begin
        hit  = 1'b0;
        part = 1'b0;
        data = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (scan_valid[j] && ent_we_reg[scan_idx[j]] && addr != 5'd0 &&
              ent_addr_reg[scan_idx[j]] == addr) begin
            hit  = 1'b1;
            part = ent_strb_reg[scan_idx[j]] != 4'hF;
            data = ent_data_reg[scan_idx[j]];
          end
        end
      end
      assign lookup_hit[gi]                        = hit;
      assign lookup_partial[gi]                    = part;
      assign lookup_data[gi*DATA_WIDTH +: DATA_WIDTH] = data;
    end
  endgenerate
endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the retire stage.
module tb_wb_retire_queue;
  localparam int LANES = 2;
  localparam int WP    = 1;
  localparam int DEPTH = 4;
  localparam int LP    = 2;
  localparam int DW    = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                in_valid;
  logic                in_allow_in;
  logic [LANES-1:0]    in_lane_valid;
  logic [LANES-1:0]    in_write_enabled;
  logic [4*LANES-1:0]  in_write_strobe;
  logic [5*LANES-1:0]  in_write_address;
  logic [DW*LANES-1:0] in_write_data;
  logic [DW*LANES-1:0] in_program_count;
  logic                flush;
  logic [WP-1:0]       rf_write_enabled;
  logic [4*WP-1:0]     rf_write_strobe;
  logic [5*WP-1:0]     rf_write_address;
  logic [DW*WP-1:0]    rf_write_data;
  logic [5*LP-1:0]     lookup_address;
  logic [LP-1:0]       lookup_hit;
  logic [LP-1:0]       lookup_partial;
  logic [DW*LP-1:0]    lookup_data;
  logic [DW*WP-1:0]    debug_program_count;
  logic [4*WP-1:0]     debug_write_enabled;
  logic [5*WP-1:0]     debug_write_address;
  logic [DW*WP-1:0]    debug_write_data;

  wb_retire_queue #(.LANES(LANES), .WRITE_PORTS(WP), .DEPTH(DEPTH),
                    .LOOKUP_PORTS(LP), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_allow_in(in_allow_in),
    .in_lane_valid(in_lane_valid), .in_write_enabled(in_write_enabled),
    .in_write_strobe(in_write_strobe), .in_write_address(in_write_address),
    .in_write_data(in_write_data), .in_program_count(in_program_count),
    .flush(flush),
    .rf_write_enabled(rf_write_enabled), .rf_write_strobe(rf_write_strobe),
    .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .lookup_address(lookup_address), .lookup_hit(lookup_hit),
    .lookup_partial(lookup_partial), .lookup_data(lookup_data),
    .debug_program_count(debug_program_count), .debug_write_enabled(debug_write_enabled),
    .debug_write_address(debug_write_address), .debug_write_data(debug_write_data)
  );

  typedef struct packed {
    logic          we;
    logic [3:0]    strb;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } ent_t;

  ent_t model_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_lane_valid = '0; in_write_enabled = '0; in_write_strobe = '0;
    in_write_address = '0; in_write_data = '0; in_program_count = '0; flush = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic we, input logic [3:0] strb,
                          input logic [4:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] pc);
    in_lane_valid[i] = v;
    in_write_enabled[i] = we;
    in_write_strobe[i*4 +: 4] = strb;
    in_write_address[i*5 +: 5] = addr;
    in_write_data[i*DW +: DW] = data;
    in_program_count[i*DW +: DW] = pc;
  endtask

  task automatic check_outputs();
    int n;
    logic en;
    logic [4:0] a;
    logic h, pt;
    logic [DW-1:0] d;
    n = model_q.size();
    check("allow_in", {63'd0, in_allow_in}, {63'd0, (DEPTH - n) >= LANES});
    for (int k = 0; k < WP; k++) begin
      en = 1'b0;
      if (k < n) en = model_q[k].we && !flush;
      check($sformatf("rf_we%0d", k), {63'd0, rf_write_enabled[k]}, {63'd0, en});
      if (k < n) begin
        check($sformatf("dbg_we%0d", k), {60'd0, debug_write_enabled[k*4 +: 4]},
              {60'd0, en ? model_q[k].strb : 4'h0});
        check($sformatf("dbg_pc%0d", k), {32'd0, debug_program_count[k*DW +: DW]}, {32'd0, model_q[k].pc});
        check($sformatf("rf_addr%0d", k), {59'd0, rf_write_address[k*5 +: 5]}, {59'd0, model_q[k].addr});
        check($sformatf("rf_data%0d", k), {32'd0, rf_write_data[k*DW +: DW]}, {32'd0, model_q[k].data});
        check($sformatf("rf_strb%0d", k), {60'd0, rf_write_strobe[k*4 +: 4]}, {60'd0, model_q[k].strb});
        check($sformatf("dbg_data%0d", k), {32'd0, debug_write_data[k*DW +: DW]}, {32'd0, model_q[k].data});
      end else begin
        check($sformatf("dbg_we%0d", k), {60'd0, debug_write_enabled[k*4 +: 4]}, 64'd0);
      end
    end
    for (int p = 0; p < LP; p++) begin
      a = lookup_address[p*5 +: 5];
      h = 1'b0; pt = 1'b0; d = '0;
      for (int i = n - 1; i >= 0; i--) begin
        if (!h && a != 5'd0 && model_q[i].we && model_q[i].addr == a) begin
          h = 1'b1; d = model_q[i].data; pt = model_q[i].strb != 4'hF;
        end
      end
      check($sformatf("lk_hit%0d", p), {63'd0, lookup_hit[p]}, {63'd0, h});
      check($sformatf("lk_part%0d", p), {63'd0, lookup_partial[p]}, {63'd0, pt});
      check($sformatf("lk_data%0d", p), {32'd0, lookup_data[p*DW +: DW]}, {32'd0, d});
    end
  endtask

  // One clock cycle: check outputs against the model, clock, then advance the model.
  task automatic cycle();
    int n;
    int dn;
    logic acc;
    ent_t e;
    #2;
    check_outputs();
    n = model_q.size();
    acc = in_valid && ((DEPTH - n) >= LANES) && !flush;
    @(posedge clock);
    if (flush) begin
      model_q.delete();
    end else begin
      dn = (n < WP) ? n : WP;
      for (int i = 0; i < dn; i++) void'(model_q.pop_front());
      if (acc) begin
        for (int i = 0; i < LANES; i++) begin
          if (in_lane_valid[i]) begin
            e.we = in_write_enabled[i]; e.strb = in_write_strobe[i*4 +: 4];
            e.addr = in_write_address[i*5 +: 5]; e.data = in_write_data[i*DW +: DW];
            e.pc = in_program_count[i*DW +: DW];
            model_q.push_back(e);
          end
        end
      end
    end
    $display("cyc %0d valid=%0b lanes=%b flush=%0b accepted=%0b pending=%0d",
             cyc, in_valid, in_lane_valid, flush, acc, model_q.size());
    cyc++;
    #1;
  endtask

  initial begin
    clear_inputs();
    lookup_address = '0;
    // Reset state
    #1;
    check("rst_allow", {63'd0, in_allow_in}, 64'd1);
    check("rst_rf_we", {63'd0, rf_write_enabled}, 64'd0);
    check("rst_dbg_we", {60'd0, debug_write_enabled}, 64'd0);
    check("rst_lk_hit", {62'd0, lookup_hit}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Single group r3=0x11, r4=0x22
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 4'hF, 5'd3, 32'h11, 32'hBFC0_0000);
    set_lane(1, 1'b1, 1'b1, 4'hF, 5'd4, 32'h22, 32'hBFC0_0004);
    cycle();
    clear_inputs();
    check("single_addr_c1", {59'd0, rf_write_address}, 64'd3);
    repeat (3) cycle();

    // Back-pressure with back-to-back full groups
    for (int g = 0; g < 5; g++) begin
      in_valid = 1'b1;
      set_lane(0, 1'b1, 1'b1, 4'hF, 5'(8 + 2 * g), 32'h100 + 32'(g), 32'h1000 + 32'(8 * g));
      set_lane(1, 1'b1, 1'b1, 4'hF, 5'(9 + 2 * g), 32'h200 + 32'(g), 32'h1004 + 32'(8 * g));
      cycle();
    end
    clear_inputs();
    repeat (5) cycle();

    // Wrap-around: 12 single-lane entries with ascending PCs
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      set_lane(0, 1'b1, 1'($urandom_range(0, 1)), 4'hF, 5'd1 + 5'(i % 8), $urandom, 32'hBFC0_0000 + 32'(4 * i));
      set_lane(1, 1'b0, 1'b0, 4'h0, 5'd0, '0, '0);
      cycle();
    end
    clear_inputs();
    repeat (2) cycle();

    // Forwarding: r5=0xA (F) then r5=0xB (3)
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 4'hF, 5'd5, 32'hA, 32'h2000);
    set_lane(1, 1'b1, 1'b1, 4'h3, 5'd5, 32'hB, 32'h2004);
    cycle();
    clear_inputs();
    lookup_address = {5'd0, 5'd5};
    cycle();
    lookup_address = {5'd5, 5'd6};
    cycle();
    cycle();

    // Non-writing entry still traces and never hits
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b0, 4'hF, 5'd7, 32'h77, 32'h3000);
    set_lane(1, 1'b0, 1'b0, 4'h0, 5'd0, '0, '0);
    cycle();
    clear_inputs();
    lookup_address = {5'd7, 5'd7};
    cycle();
    cycle();

    // Flush with count=3 and a simultaneous group
    for (int g = 0; g < 3; g++) begin
      in_valid = 1'b1;
      set_lane(0, 1'b1, 1'b1, 4'hF, 5'd10, 32'h500 + 32'(g), 32'h4000 + 32'(8 * g));
      set_lane(1, 1'b1, 1'b1, 4'hF, 5'd11, 32'h600 + 32'(g), 32'h4004 + 32'(8 * g));
      flush = (g == 2);
      if (g == 2) check("pre_flush_count", 64'(model_q.size()), 64'd3);
      cycle();
    end
    clear_inputs();
    check("post_flush_allow", {63'd0, in_allow_in}, 64'd1);
    cycle();

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      in_valid = $urandom_range(0, 3) != 0;
      for (int i = 0; i < LANES; i++)
        set_lane(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 5'($urandom_range(0, 7)), $urandom, $urandom);
      flush = $urandom_range(0, 19) == 0;
      lookup_address = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      cycle();
    end

    // Asynchronous reset mid-operation
    clear_inputs();
    in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 4'hF, 5'd12, 32'hC0, 32'h5000);
    set_lane(1, 1'b1, 1'b1, 4'hF, 5'd13, 32'hC1, 32'h5004);
    cycle();
    clear_inputs();
    lookup_address = {5'd13, 5'd12};
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_allow", {63'd0, in_allow_in}, 64'd1);
    check("mid_rst_rf_we", {63'd0, rf_write_enabled}, 64'd0);
    check("mid_rst_dbg_we", {60'd0, debug_write_enabled}, 64'd0);
    check("mid_rst_lk_hit", {62'd0, lookup_hit}, 64'd0);
    model_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
